// File: rtl/digit_word_assembler_if.sv
// Bundle for the serial digit stream entering the assembler and the parallel
// word, framing status and error count leaving it.
interface digit_word_assembler_if #(
    parameter int WORD_BITS = 36,
    parameter int ERR_W     = 8
);
    logic [WORD_BITS-1:0] digit_pulse;
    logic                 serial_in;
    logic [WORD_BITS-1:0] word_out;
    logic                 word_valid;
    logic [5:0]           digit_index;
    logic                 locked;
    logic                 sync_err;
    logic [ERR_W-1:0]     err_count;

    // Digit source / monitor side
    modport master (
        output digit_pulse, serial_in,
        input  word_out, word_valid, digit_index, locked, sync_err, err_count
    );

    // Assembler side
    modport slave (
        input  digit_pulse, serial_in,
        output word_out, word_valid, digit_index, locked, sync_err, err_count
    );
endinterface

// File: rtl/digit_word_assembler.sv
// Assembles serial bits tagged by a one-hot digit pulse train into parallel
// words, checking that the digits arrive in strict 0..WORD_BITS-1 order.
module digit_word_assembler #(
    parameter int WORD_BITS = 36,
    parameter int MSB_FIRST = 0,
    parameter int ERR_W     = 8
) (
    input logic                   clk,
    input logic                   rst,
    digit_word_assembler_if.slave bus
);
    localparam int                   IDX_W      = 6;
    localparam logic [IDX_W-1:0]     LAST_DIGIT = IDX_W'(WORD_BITS - 1);
    localparam logic [WORD_BITS-1:0] ONE        = WORD_BITS'(1);

    typedef enum logic {HUNT, RUN} state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     expDigit_q;
    logic [IDX_W-1:0]     digitIndex_q;
    logic [WORD_BITS-1:0] shift_q;
    logic [WORD_BITS-1:0] word_q;
    logic                 wordValid_q;
    logic                 syncErr_q;
    logic [ERR_W-1:0]     errCount_q;

    logic [WORD_BITS-1:0] expOnehot;
    logic                 isMatch;
    logic                 isStart;
    logic [IDX_W-1:0]     capPos;
    logic [WORD_BITS-1:0] capMask;
    logic [WORD_BITS-1:0] startMask;
    logic [WORD_BITS-1:0] shift_d;

    // Digit 0 always begins from a cleared register so nothing from an earlier word survives
    always_comb begin
        expOnehot = ONE << expDigit_q;
        isMatch   = (bus.digit_pulse == expOnehot);
        isStart   = (bus.digit_pulse == ONE);
        capPos    = (MSB_FIRST != 0) ? (LAST_DIGIT - expDigit_q) : expDigit_q;
        capMask   = bus.serial_in ? (ONE << capPos) : '0;
        startMask = bus.serial_in ? ((MSB_FIRST != 0) ? (ONE << LAST_DIGIT) : ONE) : '0;
        shift_d   = ((expDigit_q == '0) ? '0 : shift_q) | capMask;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            expDigit_q   <= '0;
            digitIndex_q <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            wordValid_q  <= 1'b0;
            syncErr_q    <= 1'b0;
            errCount_q   <= '0;
        end else begin
            wordValid_q <= 1'b0;
            syncErr_q   <= 1'b0;
            case (state_q)
                HUNT: begin
                    if (isStart) begin
                        shift_q      <= startMask;
                        expDigit_q   <= IDX_W'(1);
                        digitIndex_q <= '0;
                        state_q      <= RUN;
                    end
                end
                RUN: begin
                    if (isMatch) begin
                        digitIndex_q <= expDigit_q;
                        if (expDigit_q == LAST_DIGIT) begin
                            word_q      <= shift_d;
                            wordValid_q <= 1'b1;
                            expDigit_q  <= '0;
                        end else begin
                            shift_q    <= shift_d;
                            expDigit_q <= expDigit_q + IDX_W'(1);
                        end
                    end else begin
                        // A misplaced digit 0 is treated as the start of a fresh word
                        syncErr_q    <= 1'b1;
                        digitIndex_q <= '0;
                        if (errCount_q != '1) begin
                            errCount_q <= errCount_q + ERR_W'(1);
                        end
                        if (isStart) begin
                            shift_q    <= startMask;
                            expDigit_q <= IDX_W'(1);
                        end else begin
                            shift_q    <= '0;
                            expDigit_q <= '0;
                            state_q    <= HUNT;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.word_out    = word_q;
    assign bus.word_valid  = wordValid_q;
    assign bus.digit_index = digitIndex_q;
    assign bus.locked      = (state_q == RUN);
    assign bus.sync_err    = syncErr_q;
    assign bus.err_count   = errCount_q;
endmodule
